muldiv_hilo: RTL
================

// Module: muldiv_hilo
// PURPOSE
//   Parametrised HI/LO arithmetic unit for the pipelined MIPS core's execute stage.
//   Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and owns the HI/LO architectural registers.
//   The multiplier is fully pipelined with configurable depth; the divider is an iterative restoring FSM.
//   ready/busy outputs feed the hazard unit so that MFHI/MFLO and later HI/LO ops stall correctly.
// PARAMETERS
//   WIDTH       32  operand width; HI and LO are each WIDTH bits
//   MUL_STAGES  3   multiplier latency in cycles (>=1); one issue per cycle
// PORTS
//   clk          in   1      rising-edge clock
//   rst          in   1      asynchronous, active-low reset
//   start        in   1      op request; accepted on an edge where start & ready
//   op           in   3      000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO (others: no-op)
//   a            in   WIDTH  multiplicand / dividend / MTHI-MTLO source
//   b            in   WIDTH  multiplier / divisor
//   ready        out  1      combinational: the current start/op is accepted at the next edge
//   busy         out  1      divider FSM not IDLE, or any multiply in flight
//   done         out  1      one-cycle pulse: HI/LO just updated by a MULT*/DIV*
//   div_by_zero  out  1      one-cycle pulse with done when a DIV/DIVU had b==0
//   hi           out  WIDTH  HI register
//   lo           out  WIDTH  LO register
// BEHAVIOUR
//   Reset (rst=0, async):
//     - hi=lo=0; done=div_by_zero=0; FSM->IDLE; all multiplier valid bits cleared.
//     - An in-flight operation is abandoned and never writes HI/LO.
//   ready:
//     - MULT/MULTU: ready = (FSM==IDLE).
//     - DIV/DIVU/MTHI/MTLO: ready = (FSM==IDLE) & no multiply in flight.
//     - Reserved op codes: ready=1; the op is discarded with no state change.
//     - If ready=0, start is ignored; the requester holds op/a/b until accepted.
//   Multiply (accept edge E0):
//     - Product of a*b is 2*WIDTH bits; MULT is signed two's complement, MULTU is unsigned.
//     - {hi,lo} <= product at edge E0+MUL_STAGES; done=1 for the cycle after that edge.
//     - Back-to-back issue is allowed; results retire in order, one per cycle.
//   Divide (accept edge E0):
//     - FSM IDLE->DIV at E0; DIV runs WIDTH restoring iterations, one per edge, on magnitudes.
//     - Then DIV->FIX: apply signs; hi/lo written at edge E0+WIDTH+1; FSM->IDLE on the same edge.
//     - busy=1 for the WIDTH+1 cycles between E0 and the write edge.
//     - done=1 for the cycle after the write edge.
//     - Signed results: quotient truncates toward zero; remainder takes the dividend's sign.
//     - LO=quotient, HI=remainder.
//     - DIV of most-negative / -1: lo=most-negative, hi=0, no flag.
//   Divide by zero (b==0 at accept):
//     - FSM goes to FIX directly; hi<=a, lo<=all ones at edge E0+1.
//     - done=div_by_zero=1 in the following cycle.
//   MTHI/MTLO:
//     - hi<=a (MTHI) or lo<=a (MTLO) at the accept edge; done stays low.
//   Simultaneous events:
//     - A mult retire and an MT write can never collide; ready rules guarantee it.
//     - A new mult may be accepted on the same edge another one retires.
//   Width rules:
//     - Signed operands are sign-extended to 2*WIDTH before multiplying.
//     - The divider works on WIDTH-bit magnitudes plus a WIDTH+1-bit partial remainder.
// TESTING (WIDTH=32, MUL_STAGES=3)
//   1. MULTU a=FFFFFFFF b=2 -> 3rd edge: hi=00000001 lo=FFFFFFFE, done pulses once.
//   2. MULT a=-3 b=5, then MULT a=7 b=6, then MULT a=0 b=9 on consecutive cycles
//      -> done high 3 consecutive cycles; {hi,lo} = FFFFFFFF_FFFFFFF1, then 0_0000002A, then 0_0.
//   3. DIV a=-7 b=2 -> busy 33 cycles; lo=FFFFFFFD hi=FFFFFFFF; done once; div_by_zero=0.
//   4. DIVU a=1234 b=0 -> next edge: lo=FFFFFFFF hi=00001234; done=div_by_zero=1 for one cycle.
//   5. MULT issued, DIV start held next cycle -> ready=0 until the mult retires.
//      DIV is then accepted; the mult result is not overwritten early.
//   6. DIVU 100/7 started, rst=0 at iteration 10 -> hi=lo=0, busy=0, done never pulses.
//      A MTLO 55 after reset release -> lo=55.

Source files
------------

// File: rtl/muldiv_hilo_if.sv
// Request/result bundle between the execute stage and the HI/LO arithmetic unit.
// The master drives op requests; the slave returns handshake, status and HI/LO.
interface muldiv_hilo_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  ready, busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output ready, busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_hilo.sv
// HI/LO arithmetic unit: pipelined MULT/MULTU, iterative restoring DIV/DIVU,
// MTHI/MTLO, and the HI/LO architectural registers.
module muldiv_hilo #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_STAGES = 3
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_hilo_if.slave  bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_FIX
  } state_t;

  typedef enum logic [2:0] {
    OP_MULTU = 3'b000,
    OP_MULT  = 3'b001,
    OP_DIVU  = 3'b010,
    OP_DIV   = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_t;

  state_t state, state_next;

  logic [MUL_STAGES-1:0]  mul_vld;
  logic [2*WIDTH-1:0]     mul_pipe [MUL_STAGES];
  logic [2*WIDTH-1:0]     a_ext, b_ext, mul_prod;
  logic                   mul_busy, mul_retire;

  logic                   ready, accept;
  logic                   is_mul, is_div, is_mthi, is_mtlo;
  logic                   a_neg, b_neg, b_zero;
  logic [WIDTH-1:0]       a_mag, b_mag;

  logic [WIDTH-1:0]       div_quo, div_dsr;
  logic [WIDTH:0]         div_rem;
  logic [CW-1:0]          div_cnt;
  logic                   div_neg_q, div_neg_r, div_dz;
  logic [WIDTH:0]         div_shift;
  logic [WIDTH+1:0]       div_diff;
  logic [WIDTH-1:0]       q_res, r_res;

  logic [WIDTH-1:0]       hi_q, lo_q;
  logic                   done_q, dbz_q;

  assign mul_busy   = |mul_vld;
  assign mul_retire = mul_vld[MUL_STAGES-1];

  always_comb begin
    ready = 1'b1;
    case (bus.op)
      OP_MULTU, OP_MULT:                ready = (state == S_IDLE);
      OP_DIVU, OP_DIV, OP_MTHI, OP_MTLO: ready = (state == S_IDLE) & ~mul_busy;
      default:                          ready = 1'b1;
    endcase
  end

  assign accept  = bus.start & ready;
  assign is_mul  = accept & ((bus.op == OP_MULTU) | (bus.op == OP_MULT));
  assign is_div  = accept & ((bus.op == OP_DIVU)  | (bus.op == OP_DIV));
  assign is_mthi = accept & (bus.op == OP_MTHI);
  assign is_mtlo = accept & (bus.op == OP_MTLO);

  // op[0] selects the signed flavour for both MULT and DIV.
  assign a_neg  = bus.op[0] & bus.a[WIDTH-1];
  assign b_neg  = bus.op[0] & bus.b[WIDTH-1];
  assign b_zero = (bus.b == '0);
  assign a_mag  = a_neg ? (~bus.a + 1'b1) : bus.a;
  assign b_mag  = b_neg ? (~bus.b + 1'b1) : bus.b;

  assign a_ext    = {{WIDTH{a_neg}}, bus.a};
  assign b_ext    = {{WIDTH{b_neg}}, bus.b};
  assign mul_prod = a_ext * b_ext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_vld <= '0;
    end else begin
      mul_vld[0] <= is_mul;
      for (int unsigned i = 1; i < MUL_STAGES; i++)
        mul_vld[i] <= mul_vld[i-1];
    end
  end

  always_ff @(posedge clk) begin
    mul_pipe[0] <= mul_prod;
    for (int unsigned i = 1; i < MUL_STAGES; i++)
      mul_pipe[i] <= mul_pipe[i-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (is_div) state_next = b_zero ? S_FIX : S_DIV;
      S_DIV:  if (div_cnt == CW'(WIDTH - 1)) state_next = S_FIX;
      S_FIX:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Restoring step: shift in the next dividend bit, subtract, keep if no borrow.
  assign div_shift = {div_rem[WIDTH-1:0], div_quo[WIDTH-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, div_dsr};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_quo   <= '0;
      div_rem   <= '0;
      div_dsr   <= '0;
      div_cnt   <= '0;
      div_neg_q <= 1'b0;
      div_neg_r <= 1'b0;
      div_dz    <= 1'b0;
    end else if (is_div) begin
      // On divide-by-zero the quotient register just carries the raw dividend to HI.
      div_quo   <= b_zero ? bus.a : a_mag;
      div_rem   <= '0;
      div_dsr   <= b_mag;
      div_cnt   <= '0;
      div_neg_q <= a_neg ^ b_neg;
      div_neg_r <= a_neg;
      div_dz    <= b_zero;
    end else if (state == S_DIV) begin
      div_cnt <= div_cnt + CW'(1);
      div_quo <= {div_quo[WIDTH-2:0], ~div_diff[WIDTH+1]};
      div_rem <= div_diff[WIDTH+1] ? div_shift : div_diff[WIDTH:0];
    end
  end

  assign q_res = div_neg_q ? (~div_quo + 1'b1) : div_quo;
  assign r_res = div_neg_r ? (~div_rem[WIDTH-1:0] + 1'b1) : div_rem[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      if (mul_retire) begin
        {hi_q, lo_q} <= mul_pipe[MUL_STAGES-1];
        done_q       <= 1'b1;
      end
      if (state == S_FIX) begin
        done_q <= 1'b1;
        dbz_q  <= div_dz;
        if (div_dz) begin
          hi_q <= div_quo;
          lo_q <= '1;
        end else begin
          hi_q <= r_res;
          lo_q <= q_res;
        end
      end
      if (is_mthi) hi_q <= bus.a;
      if (is_mtlo) lo_q <= bus.a;
    end
  end

  assign bus.ready       = ready;
  assign bus.busy        = (state != S_IDLE) | mul_busy;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule
